sample_axis_packer: RTL and testbench

- Consumer for the counter sample source: takes single-cycle `data_valid` pulses carrying `sample_data`.
- Buffers samples in a small synchronous FIFO.
- Emits them as an AXI4-Stream master with TLAST framing every C_PACKET_LEN beats, toward the AXI DMA S2MM channel used in cyclic mode.
- Reports overflow when the DMA back-pressures longer than the FIFO can absorb.

---
 rtl/sample_axis_packer.sv | 216 +++++++++++++++++++++
 tb/tb_sample_axis_packer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sample_axis_packer.sv
// sample_axis_packer
//   Packs single-cycle sample strobes into an AXI4-Stream master. Samples are
//   buffered in a small synchronous FIFO. A one-word output register presents
//   them to the AXI DMA S2MM channel. TLAST is asserted every C_PACKET_LEN beats.
//
// Ports
//   ACLK, ARESET             clock (rising edge), async active-high reset
//   enable                   accept samples when high; low clears sticky flags
//   sample_data, data_valid  sample word and its one-cycle strobe
//   M_AXIS_T*                AXI4-Stream master (TDATA/TVALID/TREADY/TLAST)
//   overflow                 sticky: a sample arrived while the FIFO was full
//   fifo_level               registered FIFO occupancy, 0..C_FIFO_DEPTH
//   seq_error, seq_err_count sequence-gap monitor outputs
//
// Optional feature
//   Define SAMPLE_AXIS_PACKER_SEQ_CHECK_EN to build the sequence-gap checker.
//   Without it, seq_error and seq_err_count are tied to zero.
module sample_axis_packer #(
  parameter int C_M_AXIS_DATA_WIDTH = 32,
  parameter int C_PACKET_LEN        = 256,
  parameter int C_FIFO_DEPTH        = 16
) (
  input  logic                             ACLK,
  input  logic                             ARESET,
  input  logic                             enable,
  input  logic [C_M_AXIS_DATA_WIDTH-1:0]   sample_data,
  input  logic                             data_valid,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic                             M_AXIS_TVALID,
  input  logic                             M_AXIS_TREADY,
  output logic                             M_AXIS_TLAST,
  output logic                             overflow,
  output logic [$clog2(C_FIFO_DEPTH):0]    fifo_level,
  output logic                             seq_error,
  output logic [15:0]                      seq_err_count
);

  localparam int AW = $clog2(C_FIFO_DEPTH);
  localparam int BW = (C_PACKET_LEN > 1) ? $clog2(C_PACKET_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT  = BW'(C_PACKET_LEN - 1);
  localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(C_FIFO_DEPTH);

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

  logic [C_M_AXIS_DATA_WIDTH-1:0] mem_q [C_FIFO_DEPTH];
  logic [AW-1:0]                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]                    level_q, level_d;
  state_t                         state_q, state_d;
  logic [C_M_AXIS_DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                           tlast_q, tlast_d;
  logic [BW-1:0]                  beat_q, beat_d;
  logic                           overflow_q, overflow_d;

  logic fifo_full_s, fifo_empty_s, push_s, load_s, handshake_s;

  // Fullness uses the registered level, so a pop in the same cycle cannot make room.
  assign fifo_full_s  = (level_q == FULL_LEVEL);
  assign fifo_empty_s = (level_q == '0);
  assign push_s       = data_valid & enable & ~fifo_full_s;
  assign handshake_s  = (state_q == ST_FULL) & M_AXIS_TREADY;
  // Refill the output register whenever it is empty or being consumed this cycle.
  assign load_s       = ~fifo_empty_s & ((state_q == ST_EMPTY) | handshake_s);

  // FIFO storage write port.
  always_ff @(posedge ACLK) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= sample_data;
    end
  end

  // Output-stage state register.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Output-stage next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: state_d = fifo_empty_s ? ST_EMPTY : ST_FULL;
      ST_FULL:  state_d = (handshake_s && fifo_empty_s) ? ST_EMPTY : ST_FULL;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // Output-stage datapath: pointers, level, beat counter, presented word.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    beat_d     = beat_q;
    tdata_d    = tdata_q;
    tlast_d    = tlast_q;
    overflow_d = overflow_q;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    case ({push_s, load_s})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    if (handshake_s) begin
      beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
    end else begin
      beat_d = beat_q;
    end

    // The word being loaded is presented with the post-handshake beat count.
    if (load_s) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      tdata_d  = mem_q[rd_ptr_q];
      tlast_d  = (beat_d == LAST_BEAT);
    end else if (handshake_s) begin
      tlast_d  = 1'b0;
    end else begin
      tlast_d  = tlast_q;
    end

    if (!enable) begin
      overflow_d = 1'b0;
    end else if (data_valid && fifo_full_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      beat_q     <= '0;
      tdata_q    <= '0;
      tlast_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      beat_q     <= beat_d;
      tdata_q    <= tdata_d;
      tlast_q    <= tlast_d;
      overflow_q <= overflow_d;
    end
  end

  assign M_AXIS_TVALID = (state_q == ST_FULL);
  assign M_AXIS_TDATA  = tdata_q;
  assign M_AXIS_TLAST  = tlast_q;
  assign overflow      = overflow_q;
  assign fifo_level    = level_q;

`ifdef SAMPLE_AXIS_PACKER_SEQ_CHECK_EN
  logic [C_M_AXIS_DATA_WIDTH-1:0] seq_expect_q, seq_expect_d;
  logic                           seq_seeded_q, seq_seeded_d;
  logic                           seq_error_q, seq_error_d;
  logic [15:0]                    seq_cnt_q, seq_cnt_d;

  // Sequence checker; dropped samples are checked too, and enable low forces a reseed.
  always_comb begin
    seq_expect_d = seq_expect_q;
    seq_seeded_d = seq_seeded_q;
    seq_error_d  = seq_error_q;
    seq_cnt_d    = seq_cnt_q;
    if (!enable) begin
      seq_seeded_d = 1'b0;
      seq_error_d  = 1'b0;
    end else if (data_valid) begin
      seq_expect_d = sample_data + 1'b1;
      seq_seeded_d = 1'b1;
      if (seq_seeded_q && (sample_data != seq_expect_q)) begin
        seq_error_d = 1'b1;
        seq_cnt_d   = (seq_cnt_q == 16'hFFFF) ? seq_cnt_q : seq_cnt_q + 16'd1;
      end else begin
        seq_error_d = seq_error_q;
      end
    end else begin
      seq_seeded_d = seq_seeded_q;
    end
  end

  // Sequence checker registers.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      seq_expect_q <= '0;
      seq_seeded_q <= 1'b0;
      seq_error_q  <= 1'b0;
      seq_cnt_q    <= 16'h0000;
    end else begin
      seq_expect_q <= seq_expect_d;
      seq_seeded_q <= seq_seeded_d;
      seq_error_q  <= seq_error_d;
      seq_cnt_q    <= seq_cnt_d;
    end
  end

  assign seq_error     = seq_error_q;
  assign seq_err_count = seq_cnt_q;
`else
  assign seq_error     = 1'b0;
  assign seq_err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_sample_axis_packer.sv
module tb_sample_axis_packer;
  localparam int W     = 32;
  localparam int DEPTH = 16;
  localparam int LEN   = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0, dv = 1'b0, tready = 1'b0;
  logic [W-1:0] din = '0;

  logic [W-1:0] tdata_a, tdata_b;
  logic         tvalid_a, tvalid_b, tlast_a, tlast_b, ovf_a, ovf_b, serr_a, serr_b;
  logic [4:0]   level_a, level_b;
  logic [15:0]  scnt_a, scnt_b;

  sample_axis_packer #(.C_M_AXIS_DATA_WIDTH(W), .C_PACKET_LEN(LEN), .C_FIFO_DEPTH(DEPTH)) dut_a (
    .ACLK(clk), .ARESET(rst), .enable(en), .sample_data(din), .data_valid(dv),
    .M_AXIS_TDATA(tdata_a), .M_AXIS_TVALID(tvalid_a), .M_AXIS_TREADY(tready),
    .M_AXIS_TLAST(tlast_a), .overflow(ovf_a), .fifo_level(level_a),
    .seq_error(serr_a), .seq_err_count(scnt_a));

  sample_axis_packer #(.C_M_AXIS_DATA_WIDTH(W), .C_PACKET_LEN(1), .C_FIFO_DEPTH(DEPTH)) dut_b (
    .ACLK(clk), .ARESET(rst), .enable(en), .sample_data(din), .data_valid(dv),
    .M_AXIS_TDATA(tdata_b), .M_AXIS_TVALID(tvalid_b), .M_AXIS_TREADY(tready),
    .M_AXIS_TLAST(tlast_b), .overflow(ovf_b), .fifo_level(level_b),
    .seq_error(serr_b), .seq_err_count(scnt_b));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: buffered-word count, output-register occupancy, sticky overflow.
  int           m_cnt = 0;
  bit           m_out_valid = 1'b0;
  bit           m_ovf = 1'b0;
  logic [W-1:0] exp_a[$];
  logic [W-1:0] exp_b[$];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock, updating the model with the inputs seen at that edge.
  task automatic step();
    bit full, hs, push, pop;
    full = (m_cnt == DEPTH);
    hs   = m_out_valid && tready;
    push = dv && en && !full;
    pop  = (m_cnt > 0) && (!m_out_valid || hs);
    if (push) begin
      exp_a.push_back(din);
      exp_b.push_back(din);
    end
    @(posedge clk);
    m_cnt       = m_cnt + int'(push) - int'(pop);
    m_out_valid = pop ? 1'b1 : (hs ? 1'b0 : m_out_valid);
    m_ovf       = !en ? 1'b0 : ((dv && full) ? 1'b1 : m_ovf);
    #1;
  endtask

  task automatic drive(bit v, logic [W-1:0] d, bit e, bit r);
    dv = v; din = d; en = e; tready = r;
    step();
  endtask

  task automatic idle(int n, bit e, bit r);
    for (int i = 0; i < n; i++) drive(1'b0, '0, e, r);
  endtask

  // Monitor: per-cycle state checks and scoreboard pops on each handshake.
  initial begin : monitor
    int           beat_a;
    bit           stalled;
    logic [W-1:0] held_data;
    logic         held_last;
    logic [W-1:0] w;
    beat_a = 0; stalled = 1'b0; held_data = '0; held_last = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        beat_a  = 0;
        stalled = 1'b0;
      end else begin
        check("tvalid_a", 64'(tvalid_a), 64'(m_out_valid));
        check("tvalid_b", 64'(tvalid_b), 64'(m_out_valid));
        check("fifo_level", 64'(level_a), 64'(m_cnt));
        check("overflow", 64'(ovf_a), 64'(m_ovf));
`ifndef SAMPLE_AXIS_PACKER_SEQ_CHECK_EN
        check("seq_tied_off", {47'd0, serr_a, scnt_a}, 64'd0);
`endif
        if (stalled) begin
          check("hold_tdata", 64'(tdata_a), 64'(held_data));
          check("hold_tlast", 64'(tlast_a), 64'(held_last));
        end
        if (tvalid_a && tready) begin
          if (exp_a.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_beat_a: got %0h expected none", tdata_a);
          end else begin
            w = exp_a.pop_front();
            check("tdata_a", 64'(tdata_a), 64'(w));
            check("tlast_a", 64'(tlast_a), 64'((beat_a % LEN) == LEN - 1));
            beat_a++;
          end
          if (exp_b.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_beat_b: got %0h expected none", tdata_b);
          end else begin
            w = exp_b.pop_front();
            check("tdata_b", 64'(tdata_b), 64'(w));
            check("tlast_b", 64'(tlast_b), 64'd1);
          end
          stalled = 1'b0;
        end else if (tvalid_a) begin
          stalled   = 1'b1;
          held_data = tdata_a;
          held_last = tlast_a;
        end else begin
          stalled = 1'b0;
        end
      end
    end
  end

  initial begin : stimulus
    #1 rst = 1'b1;
    #2;
    check("rst_tvalid", 64'(tvalid_a), 64'd0);
    check("rst_tlast", 64'(tlast_a), 64'd0);
    check("rst_tdata", 64'(tdata_a), 64'd0);
    check("rst_level", 64'(level_a), 64'd0);
    check("rst_overflow", 64'(ovf_a), 64'd0);
    check("rst_seq", {47'd0, serr_a, scnt_a}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Two packets of 4 at full throughput.
    for (int i = 1; i <= 8; i++) drive(1'b1, W'(i), 1'b1, 1'b1);
    idle(6, 1'b1, 1'b1);

    // Stall the sink long enough to overflow the FIFO.
    for (int i = 1; i <= 20; i++) drive(1'b1, W'(i), 1'b1, 1'b0);
    idle(1, 1'b1, 1'b0);
    check("ovf_level16", 64'(level_a), 64'd16);
    check("ovf_flag", 64'(ovf_a), 64'd1);
    check("ovf_outreg", 64'(tdata_a), 64'd1);
    idle(20, 1'b1, 1'b1);
    idle(1, 1'b0, 1'b1);
    check("ovf_cleared", 64'(ovf_a), 64'd0);

    // Ready toggling every cycle while a packet streams.
    for (int i = 0; i < 12; i++) drive(1'b1, W'($urandom), 1'b1, bit'(i % 2));
    for (int i = 0; i < 24; i++) drive(1'b0, '0, 1'b1, bit'(i % 2));

    // Randomized traffic, enable and back-pressure.
    for (int i = 0; i < 400; i++)
      drive(bit'($urandom_range(0, 1)), W'($urandom), $urandom_range(0, 9) != 0,
            $urandom_range(0, 9) < 6);
    idle(30, 1'b1, 1'b1);

    // Asynchronous reset in the middle of a packet with five words buffered.
    for (int i = 0; i < 2; i++) drive(1'b1, W'(200 + i), 1'b1, 1'b1);
    idle(3, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) drive(1'b1, W'(300 + i), 1'b1, 1'b0);
    idle(1, 1'b1, 1'b0);
    check("pre_rst_level5", 64'(level_a), 64'd5);
    rst = 1'b1;
    #1;
    check("mid_rst_tvalid", 64'(tvalid_a), 64'd0);
    check("mid_rst_tlast", 64'(tlast_a), 64'd0);
    check("mid_rst_level", 64'(level_a), 64'd0);
    m_cnt = 0; m_out_valid = 1'b0; m_ovf = 1'b0;
    exp_a.delete(); exp_b.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) drive(1'b1, W'(400 + i), 1'b1, 1'b1);
    idle(6, 1'b1, 1'b1);

`ifdef SAMPLE_AXIS_PACKER_SEQ_CHECK_EN
    idle(1, 1'b0, 1'b1);
    drive(1'b1, W'(10), 1'b1, 1'b1);
    drive(1'b1, W'(11), 1'b1, 1'b1);
    drive(1'b1, W'(12), 1'b1, 1'b1);
    drive(1'b1, W'(15), 1'b1, 1'b1);
    drive(1'b1, W'(16), 1'b1, 1'b1);
    idle(1, 1'b1, 1'b1);
    check("seq_error_set", 64'(serr_a), 64'd1);
    check("seq_count_1", 64'(scnt_a), 64'd1);
    idle(1, 1'b0, 1'b1);
    check("seq_error_clr", 64'(serr_a), 64'd0);
    drive(1'b1, W'(100), 1'b1, 1'b1);
    drive(1'b1, W'(101), 1'b1, 1'b1);
    idle(1, 1'b1, 1'b1);
    check("seq_no_new_err", 64'(serr_a), 64'd0);
    check("seq_count_kept", 64'(scnt_a), 64'd1);
`else
    for (int i = 0; i < 5; i++) drive(1'b1, W'(i * 3), 1'b1, 1'b1);
`endif

    idle(40, 1'b1, 1'b1);
    check("scoreboard_drained", 64'(exp_a.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
